data_mem_stage: RTL and testbench
=================================

# data_mem_stage

Memory-access (MEM) stage of the pipelined mini-CPU: sits between the EX/MEM pipeline register and the MEM/WB register and holds a word-addressed data memory with fixed multi-cycle access latency. It accepts load/store requests from EX/MEM, asserts a stall to freeze the upstream pipeline for the access duration, and presents write-back control, ALU result and load data to MEM/WB. It inserts a bubble while stalled and flags misaligned accesses.

## Interface
- DEPTH, 256: data memory size in 32-bit words (power of two).
- AW, 8: word-address width, log2(DEPTH).
- MEM_LAT, 2: access latency in cycles (≥1); equals the number of stall cycles per access.
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- mvalid  in  1  EX/MEM holds a valid instruction.
- mwreg  in  1  instruction writes the register file.
- mm2reg  in  1  load: write-back data comes from memory.
- mwmem  in  1  store.
- mtemp  in  5  destination register number.
- mr  in  32  ALU result / byte address.
- mb  in  32  store data.
- wbwreg  out  1  to MEM/WB: gated register-write enable.
- wbm2reg  out  1  to MEM/WB: load select, pass-through.
- wbtemp  out  5  to MEM/WB: destination, pass-through.
- wbr  out  32  to MEM/WB: ALU result, pass-through.
- do  out  32  registered load data.
- mstall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- misalign  out  1  one-cycle pulse: misaligned access dropped.

## Operation
- Request: mvalid & (mm2reg | mwmem) & mr[1:0]==0. mm2reg and mwmem both high is treated as a store (mm2reg ignored for access).
- Word index = mr[AW+1:2]; address bits above AW+1 ignored (wrap modulo DEPTH).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: request -> stall cycle 1; if MEM_LAT==1 commit at this edge and go DONE, else go BUSY. No request -> stay IDLE.
  - BUSY: down-counter tracks remaining stall cycles; on the last, commit and go DONE.
  - DONE: mstall=0, instruction completes; always return to IDLE next edge (the same frozen instruction is not re-issued).
- Commit: store writes mb to mem[index]; load loads mem[index] into do. do holds its value otherwise.
- mstall = (IDLE & request) | BUSY; combinational so upstream freezes in the request cycle.
- wbwreg = mwreg & mvalid & ~mstall & ~misalign-condition; wbm2reg, wbtemp, wbr pass through combinationally. MEM/WB thus captures a bubble on every stall cycle and the real instruction in DONE.
- Misaligned (mvalid & (mm2reg|mwmem) & mr[1:0]!=0): no stall, no memory write, do unchanged, wbwreg=0, misalign registered high for the next cycle only.
- Memory array is not cleared by reset.

## Timing
- Reset values: state IDLE, counter 0, do=0, misalign=0; mstall=0 and wbwreg=0 unless inputs dictate otherwise after reset.
- Load/store: mstall high exactly MEM_LAT consecutive cycles from request cycle; data committed at edge ending last stall cycle; next cycle (DONE) do valid, wbwreg=mwreg; MEM/WB captures at end of DONE cycle.
- Back-to-back accesses: each costs MEM_LAT stall cycles + 1 DONE cycle; request seen in DONE is not started (the DONE instruction is the frozen one); new request starts in following IDLE.
- Non-memory instructions: zero stall, pass through same cycle.
- rst mid-BUSY: FSM to IDLE, pending store aborted (memory unchanged), do=0.
- misalign asserted the cycle after detection, deasserted following cycle.

## Test plan
- Reset: rst high 2 cycles -> do=0, mstall=0, misalign=0, state IDLE.
- Store/load, MEM_LAT=2: store mb=0xDEADBEEF mr=0x10 -> mstall high 2 cycles, wbwreg=0 throughout; then load mr=0x10, mwreg=1, mtemp=5 -> mstall 2 cycles, DONE cycle do=0xDEADBEEF, wbwreg=1, wbtemp=5.
- ALU pass-through: mvalid=1, mwreg=1, mm2reg=0, mwmem=0, mr=0x1234 -> mstall=0, wbwreg=1, wbr=0x1234 same cycle.
- Wrap: store 0x0000AAAA at mr=0x400 (DEPTH=256) -> load from mr=0x0 returns 0x0000AAAA.
- Misaligned load mr=0x13 -> no stall, wbwreg=0, misalign pulses 1 cycle, do unchanged.
- Reset mid-store: store 0x55 to mr=0x20, rst in BUSY -> load 0x20 afterward returns prior contents, not 0x55.

Source files
------------

// File: rtl/data_mem_stage.sv
// MEM stage: word-addressed data memory with fixed multi-cycle latency. Stalls the upstream
// pipeline for each access, feeds MEM/WB with gated write-back control and flags misaligned accesses.
module data_mem_stage #(
   parameter int DEPTH   = 256,
   parameter int AW      = 8,
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mvalid,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic        mwmem,
   input  logic [4:0]  mtemp,
   input  logic [31:0] mr,
   input  logic [31:0] mb,
   output logic        wbwreg,
   output logic        wbm2reg,
   output logic [4:0]  wbtemp,
   output logic [31:0] wbr,
   output logic [31:0] dout,
   output logic        mstall,
   output logic        misalign
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_do;
   logic            r_mis;
   logic [31:0]     r_mem [DEPTH];

   logic            w_mem_op;
   logic            w_req;
   logic            w_mis;
   logic            w_commit;
   logic [AW-1:0]   w_idx;
   logic            w_unused;

   assign w_mem_op = mvalid & (mm2reg | mwmem);
   assign w_req    = w_mem_op & (mr[1:0] == 2'b00);
   assign w_mis    = w_mem_op & (mr[1:0] != 2'b00);
   // Upper address bits are dropped so accesses wrap modulo DEPTH.
   assign w_idx    = mr[AW+1:2];
   assign w_unused = &{1'b0, mr[31:AW+2]};

   assign w_commit = ((r_state == S_IDLE) & w_req & (MEM_LAT == 1)) |
                     ((r_state == S_BUSY) & (r_cnt == CW'(1)));

   assign mstall   = ((r_state == S_IDLE) & w_req) | (r_state == S_BUSY);
   assign wbwreg   = mwreg & mvalid & ~mstall & ~w_mis;
   assign wbm2reg  = mm2reg;
   assign wbtemp   = mtemp;
   assign wbr      = mr;
   assign dout     = r_do;
   assign misalign = r_mis;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_do    <= '0;
         r_mis   <= 1'b0;
      end else begin
         r_mis <= w_mis;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (MEM_LAT == 1) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_BUSY;
                     r_cnt   <= CW'(MEM_LAT - 1);
                  end
               end
            end
            S_BUSY: begin
               if (r_cnt == CW'(1)) begin
                  r_state <= S_DONE;
               end
               r_cnt <= r_cnt - CW'(1);
            end
            // The instruction still sitting in EX/MEM is the one just served; never restart it.
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         if (w_commit && !mwmem) begin
            r_do <= r_mem[w_idx];
         end
      end
   end

   // Array is never reset; reset only blocks an in-flight store from landing.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && mwmem) begin
         r_mem[w_idx] <= mb;
      end
   end

endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: directed scenarios followed by random traffic checked against
// an array-based model of the memory and load-data register.
module tb_data_mem_stage;

   localparam int DEPTH   = 256;
   localparam int AW      = 8;
   localparam int MEM_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        mvalid, mwreg, mm2reg, mwmem;
   logic [4:0]  mtemp;
   logic [31:0] mr, mb;
   logic        wbwreg, wbm2reg;
   logic [4:0]  wbtemp;
   logic [31:0] wbr, dout;
   logic        mstall, misalign;

   int          errors = 0;
   int          checks = 0;

   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_do;
   logic [31:0] stored_addrs [$];

   data_mem_stage #(.DEPTH(DEPTH), .AW(AW), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst(rst), .mvalid(mvalid), .mwreg(mwreg), .mm2reg(mm2reg),
      .mwmem(mwmem), .mtemp(mtemp), .mr(mr), .mb(mb), .wbwreg(wbwreg),
      .wbm2reg(wbm2reg), .wbtemp(wbtemp), .wbr(wbr), .dout(dout),
      .mstall(mstall), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] addr);
      return int'((addr / 4) % DEPTH);
   endfunction

   task automatic drive_idle();
      @(negedge clk);
      mvalid = 1'b0; mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
      mtemp = 5'd0; mr = 32'd0; mb = 32'd0;
   endtask

   // Full aligned access: stall for MEM_LAT cycles, then one completion cycle.
   task automatic mem_access(input bit st, input bit m2r, input logic [31:0] addr,
                             input logic [31:0] data, input bit wreg, input logic [4:0] tmp);
      @(negedge clk);
      mvalid = 1'b1; mwmem = st; mm2reg = m2r; mwreg = wreg;
      mtemp = tmp; mr = addr; mb = data;
      for (int c = 0; c < MEM_LAT; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         check("stall", {31'd0, mstall}, 32'd1);
         check("bubble_wreg", {31'd0, wbwreg}, 32'd0);
      end
      if (st) m_mem[widx(addr)] = data;
      else    m_do = m_mem[widx(addr)];
      @(negedge clk); #1;
      check("done_stall", {31'd0, mstall}, 32'd0);
      check("done_wreg", {31'd0, wbwreg}, {31'd0, wreg});
      check("done_do", dout, m_do);
      check("done_wbtemp", {27'd0, wbtemp}, {27'd0, tmp});
      check("done_wbr", wbr, addr);
      check("done_wbm2reg", {31'd0, wbm2reg}, {31'd0, m2r});
   endtask

   task automatic alu_op(input logic [31:0] val, input bit wreg, input logic [4:0] tmp);
      @(negedge clk);
      mvalid = 1'b1; mwmem = 1'b0; mm2reg = 1'b0; mwreg = wreg; mtemp = tmp; mr = val;
      #1;
      check("alu_stall", {31'd0, mstall}, 32'd0);
      check("alu_wreg", {31'd0, wbwreg}, {31'd0, wreg});
      check("alu_wbr", wbr, val);
      check("alu_wbtemp", {27'd0, wbtemp}, {27'd0, tmp});
   endtask

   task automatic misaligned_op(input bit st, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      mvalid = 1'b1; mwmem = st; mm2reg = ~st; mwreg = 1'b1; mr = addr; mb = data;
      #1;
      check("mis_stall", {31'd0, mstall}, 32'd0);
      check("mis_wreg", {31'd0, wbwreg}, 32'd0);
      drive_idle();
      #1;
      check("mis_pulse", {31'd0, misalign}, 32'd1);
      check("mis_do", dout, m_do);
      @(negedge clk); #1;
      check("mis_clear", {31'd0, misalign}, 32'd0);
   endtask

   initial begin
      logic [31:0] a, d;
      int          kind;
      rst = 1'b1;
      mvalid = 1'b0; mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
      mtemp = 5'd0; mr = 32'd0; mb = 32'd0;
      m_do = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_do", dout, 32'd0);
      check("rst_stall", {31'd0, mstall}, 32'd0);
      check("rst_misalign", {31'd0, misalign}, 32'd0);
      check("rst_wreg", {31'd0, wbwreg}, 32'd0);

      mem_access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0);
      mem_access(1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 5'd5);
      check("load_deadbeef", dout, 32'hDEADBEEF);

      alu_op(32'h1234, 1'b1, 5'd7);

      mem_access(1'b1, 1'b0, 32'h400, 32'h0000AAAA, 1'b0, 5'd0);
      mem_access(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 5'd3);
      check("wrap_load", dout, 32'h0000AAAA);

      misaligned_op(1'b0, 32'h13, 32'h0);

      // Reset while a store is in flight: memory must keep its prior word.
      mem_access(1'b1, 1'b0, 32'h20, 32'h11111111, 1'b0, 5'd0);
      @(negedge clk);
      mvalid = 1'b1; mwmem = 1'b1; mm2reg = 1'b0; mwreg = 1'b0; mr = 32'h20; mb = 32'h55;
      #1;
      check("abort_stall", {31'd0, mstall}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mvalid = 1'b0; mwmem = 1'b0;
      m_do = 32'd0;
      #1;
      check("abort_do", dout, 32'd0);
      check("abort_stall_clr", {31'd0, mstall}, 32'd0);
      mem_access(1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 5'd9);
      check("abort_kept", dout, 32'h11111111);

      stored_addrs.push_back(32'h10);
      stored_addrs.push_back(32'h0);
      stored_addrs.push_back(32'h20);
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 3));
         d = $urandom;
         case (kind)
            0: begin
               a = $urandom & 32'hFFFF_FFFC;
               mem_access(1'b1, 1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)));
               stored_addrs.push_back(a);
            end
            1: begin
               a = stored_addrs[$urandom_range(0, stored_addrs.size() - 1)];
               a = a ^ ({$urandom} << (AW + 2));
               mem_access(1'b0, 1'b1, a, 32'h0, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)));
            end
            2: alu_op(d, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            default: begin
               a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
               misaligned_op(1'($urandom_range(0, 1)), a, d);
            end
         endcase
      end

      drive_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
